// File: rtl/loopback_emu_pkg.sv
// Shared definitions for the loopback channel emulator.
// Holds the rotation codes, the noise LFSR tap mask and next-state helper,
// the default LFSR seeds, and the saturating clip helper used by stage 3.
package loopback_emu_pkg;

  // Quadrature rotation codes as carried by CFG_ROT
  localparam logic [1:0] ROT_0   = 2'd0;
  localparam logic [1:0] ROT_P90 = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_M90 = 2'd3;

  // Taps of x^16+x^14+x^13+x^11+1 for a left-shifting Fibonacci LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [15:0] DEFAULT_SEED_I = 16'hACE1;
  localparam logic [15:0] DEFAULT_SEED_Q = 16'h1D2B;

  // One LFSR step: shift left, parity of the tapped bits enters bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Clip a wide signed value to the range of a w-bit two's complement number
  function automatic logic signed [31:0] sat_clip(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/loopback_channel_emu_if.sv
// Sample-stream bundle of the loopback channel.
// DAC_* carry Tx samples into the channel, ADC_* carry channel output to Rx.
// master: the Tx/Rx side (drives DAC_*, observes ADC_*).
// slave : the channel emulator (observes DAC_*, drives ADC_*).
interface loopback_channel_emu_if #(
  parameter int DW = 12
);
  logic signed [DW-1:0] DAC_I;
  logic signed [DW-1:0] DAC_Q;
  logic                 DAC_valid;
  logic signed [DW-1:0] ADC_I;
  logic signed [DW-1:0] ADC_Q;
  logic                 ADC_valid;

  modport master (output DAC_I, DAC_Q, DAC_valid, input ADC_I, ADC_Q, ADC_valid);
  modport slave  (input DAC_I, DAC_Q, DAC_valid, output ADC_I, ADC_Q, ADC_valid);
endinterface

// File: rtl/loopback_channel_emu_delay_line.sv
// Programmable sample delay for the packed I/Q stream.
// Ports: clk/rst_n; wr_valid + data = one stage-3 sample per valid cycle;
// delay = samples of extra delay (0 bypasses the buffer); flush drops the
// fill history; rd_valid/rd_data = combinational sample for this cycle.
module emu_delay_line #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [W-1:0]             data,
  input  logic [$clog2(DEPTH)-1:0] delay,
  input  logic                     flush,
  output logic                     rd_valid,
  output logic [W-1:0]             rd_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] fill_r;

  // Read side: the sample written 'delay' writes ago; the slot cannot have
  // been overwritten yet because delay never exceeds DEPTH-1
  always_comb begin
    rd_valid = wr_valid && (fill_r >= delay);
    if (delay == {AW{1'b0}}) begin
      rd_data = data;
    end else begin
      rd_data = mem_r[wptr_r - delay];
    end
  end

  // Write pointer and saturating fill count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {AW{1'b0}};
      fill_r <= {AW{1'b0}};
    end else if (flush) begin
      fill_r <= {AW{1'b0}};
    end else if (wr_valid) begin
      wptr_r <= wptr_r + AW'(1);
      if (fill_r != AW'(DEPTH - 1)) begin
        fill_r <= fill_r + AW'(1);
      end
    end
  end

  // Sample storage; contents are only read once covered by the fill count
  always_ff @(posedge clk) begin
    if (wr_valid && !flush) begin
      mem_r[wptr_r] <= data;
    end
  end
endmodule

// File: rtl/loopback_channel_emu.sv
// Deterministic I/Q loopback channel between Tx DAC and Rx ADC.
// Pipeline: rotate -> gain -> shift+noise+DC+saturate -> delay line -> ADC regs.
// Ports: clk_16M384/rst_n_16M384 clock and async reset; io = sample bundle
// (DAC_* in, ADC_* out); CFG_* runtime config captured on CFG_LOAD into
// shadow registers; CFG_ACK pulses the cycle after a load; SAT_CNT counts
// saturated output samples (sticky at all-ones, cleared by CFG_LOAD).
module loopback_channel_emu
  import loopback_emu_pkg::*;
#(
  parameter int          DW     = 12,
  parameter int          GW     = 8,
  parameter int          NW     = 6,
  parameter int          DEPTH  = 16,
  parameter logic [15:0] SEED_I = DEFAULT_SEED_I,
  parameter logic [15:0] SEED_Q = DEFAULT_SEED_Q
) (
  input  logic                     clk_16M384,
  input  logic                     rst_n_16M384,
  loopback_channel_emu_if.slave    io,
  input  logic [1:0]               CFG_ROT,
  input  logic [GW-1:0]            CFG_GAIN,
  input  logic [3:0]               CFG_GAIN_SHIFT,
  input  logic [2:0]               CFG_NOISE_BITS,
  input  logic signed [DW-1:0]     CFG_DC,
  input  logic [$clog2(DEPTH)-1:0] CFG_DELAY,
  input  logic                     CFG_LOAD,
  output logic                     CFG_ACK,
  output logic [15:0]              SAT_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW + GW + 1;
  localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

  // Negation that maps the most-negative code to +max instead of wrapping
  function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] x);
    if (x == S_MIN) begin
      return S_MAX;
    end else begin
      return -x;
    end
  endfunction

  logic [1:0]           rot_r;
  logic [GW-1:0]        gain_r;
  logic [3:0]           shift_r;
  logic [2:0]           nb_r;
  logic signed [DW-1:0] dc_r;
  logic [AW-1:0]        delay_r;
  logic                 ack_r;

  logic                 v1_r, v2_r, v3_r;
  logic signed [DW-1:0] rot_i_s, rot_q_s, r1_i_r, r1_q_r;
  logic signed [PW-1:0] p_i_s, p_q_s, p2_i_r, p2_q_r;
  logic [15:0]          lfsr_i_r, lfsr_q_r;
  logic [2:0]           nbc_s;
  logic [15:0]          mask_s;
  logic signed [31:0]   noise_i_s, noise_q_s, sum_i_s, sum_q_s;
  logic signed [DW-1:0] y_i_s, y_q_s, y3_i_r, y3_q_r;
  logic                 sat_s;
  logic [15:0]          sat_cnt_r;

  logic                 dl_wr_s;
  logic                 dl_rd_valid_s;
  logic [2*DW-1:0]      dl_rd_data_s;
  logic signed [DW-1:0] adc_i_r, adc_q_r;
  logic                 adc_valid_r;

  // Shadow configuration and load acknowledge
  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      rot_r   <= ROT_0;
      gain_r  <= GW'(1);
      shift_r <= 4'd0;
      nb_r    <= 3'd0;
      dc_r    <= {DW{1'b0}};
      delay_r <= {AW{1'b0}};
      ack_r   <= 1'b0;
    end else begin
      ack_r <= CFG_LOAD;
      if (CFG_LOAD) begin
        rot_r   <= CFG_ROT;
        gain_r  <= CFG_GAIN;
        shift_r <= CFG_GAIN_SHIFT;
        nb_r    <= CFG_NOISE_BITS;
        dc_r    <= CFG_DC;
        delay_r <= CFG_DELAY;
      end
    end
  end

  // Stage 1 combinational rotation
  always_comb begin
    rot_i_s = io.DAC_I;
    rot_q_s = io.DAC_Q;
    case (rot_r)
      ROT_0:   begin rot_i_s = io.DAC_I;          rot_q_s = io.DAC_Q;          end
      ROT_P90: begin rot_i_s = neg_sat(io.DAC_Q); rot_q_s = io.DAC_I;          end
      ROT_180: begin rot_i_s = neg_sat(io.DAC_I); rot_q_s = neg_sat(io.DAC_Q); end
      ROT_M90: begin rot_i_s = io.DAC_Q;          rot_q_s = neg_sat(io.DAC_I); end
      default: begin rot_i_s = io.DAC_I;          rot_q_s = io.DAC_Q;          end
    endcase
  end

  // Stage 2 gain and stage 3 shift/noise/offset/saturate
  always_comb begin
    p_i_s  = PW'(r1_i_r) * $signed({{(PW-GW){1'b0}}, gain_r});
    p_q_s  = PW'(r1_q_r) * $signed({{(PW-GW){1'b0}}, gain_r});
    nbc_s  = (nb_r > 3'(NW)) ? 3'(NW) : nb_r;
    mask_s = (16'd1 << nbc_s) - 16'd1;
    if (nbc_s == 3'd0) begin
      noise_i_s = 32'sd0;
      noise_q_s = 32'sd0;
    end else begin
      // Offset-binary noise: low bits of the LFSR re-centred around zero
      noise_i_s = $signed({16'd0, lfsr_i_r & mask_s}) - (32'sd1 <<< (nbc_s - 3'd1));
      noise_q_s = $signed({16'd0, lfsr_q_r & mask_s}) - (32'sd1 <<< (nbc_s - 3'd1));
    end
    sum_i_s = (32'(p2_i_r) >>> shift_r) + noise_i_s + 32'(dc_r);
    sum_q_s = (32'(p2_q_r) >>> shift_r) + noise_q_s + 32'(dc_r);
    y_i_s   = DW'(sat_clip(sum_i_s, DW));
    y_q_s   = DW'(sat_clip(sum_q_s, DW));
    sat_s   = (sat_clip(sum_i_s, DW) != sum_i_s) || (sat_clip(sum_q_s, DW) != sum_q_s);
  end

  // Pipeline registers; CFG_LOAD flushes every in-flight sample
  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      v3_r   <= 1'b0;
      r1_i_r <= {DW{1'b0}};
      r1_q_r <= {DW{1'b0}};
      p2_i_r <= {PW{1'b0}};
      p2_q_r <= {PW{1'b0}};
      y3_i_r <= {DW{1'b0}};
      y3_q_r <= {DW{1'b0}};
    end else begin
      if (CFG_LOAD) begin
        v1_r <= 1'b0;
        v2_r <= 1'b0;
        v3_r <= 1'b0;
      end else begin
        v1_r <= io.DAC_valid;
        v2_r <= v1_r;
        v3_r <= v2_r;
      end
      if (io.DAC_valid) begin
        r1_i_r <= rot_i_s;
        r1_q_r <= rot_q_s;
      end
      if (v1_r) begin
        p2_i_r <= p_i_s;
        p2_q_r <= p_q_s;
      end
      if (v2_r) begin
        y3_i_r <= y_i_s;
        y3_q_r <= y_q_s;
      end
    end
  end

  // Noise LFSRs step once per valid sample passing through stage 3, so
  // each sample sees a fresh state and idle cycles do not consume noise
  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      lfsr_i_r <= SEED_I;
      lfsr_q_r <= SEED_Q;
    end else if (v2_r && !CFG_LOAD) begin
      lfsr_i_r <= lfsr_next(lfsr_i_r);
      lfsr_q_r <= lfsr_next(lfsr_q_r);
    end
  end

  // Saturation counter, sticky at all-ones
  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      sat_cnt_r <= 16'd0;
    end else if (CFG_LOAD) begin
      sat_cnt_r <= 16'd0;
    end else if (v2_r && sat_s && (sat_cnt_r != 16'hFFFF)) begin
      sat_cnt_r <= sat_cnt_r + 16'd1;
    end
  end

  assign dl_wr_s = v3_r && !CFG_LOAD;

  emu_delay_line #(
    .W     (2 * DW),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk      (clk_16M384),
    .rst_n    (rst_n_16M384),
    .wr_valid (dl_wr_s),
    .data     ({y3_i_r, y3_q_r}),
    .delay    (delay_r),
    .flush    (CFG_LOAD),
    .rd_valid (dl_rd_valid_s),
    .rd_data  (dl_rd_data_s)
  );

  // Output registers hold their last sample while no valid output is due
  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      adc_i_r     <= {DW{1'b0}};
      adc_q_r     <= {DW{1'b0}};
      adc_valid_r <= 1'b0;
    end else begin
      adc_valid_r <= dl_rd_valid_s;
      if (dl_rd_valid_s) begin
        adc_i_r <= $signed(dl_rd_data_s[2*DW-1:DW]);
        adc_q_r <= $signed(dl_rd_data_s[DW-1:0]);
      end
    end
  end

  assign io.ADC_I     = adc_i_r;
  assign io.ADC_Q     = adc_q_r;
  assign io.ADC_valid = adc_valid_r;
  assign CFG_ACK      = ack_r;
  assign SAT_CNT      = sat_cnt_r;
endmodule

// File: tb/tb_loopback_channel_emu.sv
// Scoreboard bench for loopback_channel_emu: the driver pushes the expected
// ADC sample and its expected arrival cycle; a monitor pops on ADC_valid.
module tb_loopback_channel_emu;
  localparam int DW = 12;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  loopback_channel_emu_if #(.DW(DW)) io ();

  logic [1:0]           cfg_rot;
  logic [GW-1:0]        cfg_gain;
  logic [3:0]           cfg_shift;
  logic [2:0]           cfg_nb;
  logic signed [DW-1:0] cfg_dc;
  logic [3:0]           cfg_delay;
  logic                 cfg_load;
  logic                 cfg_ack;
  logic [15:0]          sat_cnt;

  loopback_channel_emu dut (
    .clk_16M384     (clk),
    .rst_n_16M384   (rst_n),
    .io             (io),
    .CFG_ROT        (cfg_rot),
    .CFG_GAIN       (cfg_gain),
    .CFG_GAIN_SHIFT (cfg_shift),
    .CFG_NOISE_BITS (cfg_nb),
    .CFG_DC         (cfg_dc),
    .CFG_DELAY      (cfg_delay),
    .CFG_LOAD       (cfg_load),
    .CFG_ACK        (cfg_ack),
    .SAT_CNT        (sat_cnt)
  );

  typedef struct { int i; int q; int cyc; } exp_t;
  typedef struct { int i; int q; } smp_t;

  exp_t        sbq[$];
  smp_t        hist[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          d_m = 0;
  logic [15:0] lfsr_i_m, lfsr_q_m;
  bit          noise_phase = 1'b0;
  longint      sum_i_obs = 0;
  longint      sum_q_obs = 0;
  int          range_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic void check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endfunction

  // Monitor: compare every presented output against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && io.ADC_valid) begin
        out_cnt++;
        if (noise_phase) begin
          sum_i_obs += int'(io.ADC_I);
          sum_q_obs += int'(io.ADC_Q);
          if (io.ADC_I < -16 || io.ADC_I > 15 || io.ADC_Q < -16 || io.ADC_Q > 15) range_bad++;
        end
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got I=%0d Q=%0d at cyc %0d required no output",
                   io.ADC_I, io.ADC_Q, cyc);
        end else begin
          e = sbq.pop_front();
          if (int'(io.ADC_I) != e.i || int'(io.ADC_Q) != e.q || cyc != e.cyc) begin
            bad++;
            $display("FAIL sample: got I=%0d Q=%0d cyc=%0d required I=%0d Q=%0d cyc=%0d",
                     io.ADC_I, io.ADC_Q, cyc, e.i, e.q, e.cyc);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      io.DAC_valid = 1'b0;
    end
  endtask

  // Issue one valid sample whose stage-3 result is (ei, eq)
  task automatic send(input int i, input int q, input int ei, input int eq);
    smp_t s;
    int   k;
    @(negedge clk);
    io.DAC_I     = DW'(i);
    io.DAC_Q     = DW'(q);
    io.DAC_valid = 1'b1;
    s.i = ei;
    s.q = eq;
    hist.push_back(s);
    k = hist.size() - 1;
    if (k >= d_m) sbq.push_back('{hist[k-d_m].i, hist[k-d_m].q, cyc + 4});
    lfsr_i_m = model_step(lfsr_i_m);
    lfsr_q_m = model_step(lfsr_q_m);
  endtask

  // Load a configuration; optionally offer a sample in the load cycle (dropped)
  task automatic cfg(input int rot, input int gain, input int shift, input int nb,
                     input int dc, input int dly, input bit with_sample);
    @(negedge clk);
    cfg_rot      = 2'(rot);
    cfg_gain     = GW'(gain);
    cfg_shift    = 4'(shift);
    cfg_nb       = 3'(nb);
    cfg_dc       = DW'(dc);
    cfg_delay    = 4'(dly);
    cfg_load     = 1'b1;
    io.DAC_I     = 12'sd77;
    io.DAC_Q     = -12'sd77;
    io.DAC_valid = with_sample;
    sbq.delete();
    hist.delete();
    d_m = dly;
    @(posedge clk);
    #1;
    check("cfg_ack_high", int'(cfg_ack), 1);
    check("sat_cnt_after_load", int'(sat_cnt), 0);
    @(negedge clk);
    cfg_load     = 1'b0;
    io.DAC_valid = 1'b0;
    // Scramble the live inputs: the datapath must keep using the shadow copy
    cfg_rot   = 2'd2;
    cfg_gain  = 8'd0;
    cfg_shift = 4'd7;
    cfg_nb    = 3'd4;
    cfg_dc    = 12'sd100;
    cfg_delay = 4'd9;
    @(posedge clk);
    #1;
    check("cfg_ack_low", int'(cfg_ack), 0);
  endtask

  task automatic model_reset();
    sbq.delete();
    hist.delete();
    d_m      = 0;
    lfsr_i_m = 16'hACE1;
    lfsr_q_m = 16'h1D2B;
  endtask

  initial begin
    int o0;
    int ei, eq;
    cfg_rot = 2'd0; cfg_gain = 8'd1; cfg_shift = 4'd0; cfg_nb = 3'd0;
    cfg_dc = 12'sd0; cfg_delay = 4'd0; cfg_load = 1'b0;
    io.DAC_I = 12'sd0; io.DAC_Q = 12'sd0; io.DAC_valid = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_adc_i", int'(io.ADC_I), 0);
    check("rst_adc_q", int'(io.ADC_Q), 0);
    check("rst_adc_valid", int'(io.ADC_valid), 0);
    check("rst_cfg_ack", int'(cfg_ack), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity ramp with periodic input gaps
    o0 = out_cnt;
    for (int k = 0; k < 100; k++) begin
      send(k, -k, k, -k);
      if (k % 7 == 6) idle(2);
    end
    idle(6);
    check("ramp_count", out_cnt - o0, 100);

    // Rotation -90, gain 3, shift 2, DC -16
    cfg(3, 3, 2, 0, -16, 0, 1'b0);
    send(400, -200, -166, -316);
    idle(6);
    check("hold_adc_i", int'(io.ADC_I), -166);
    check("hold_adc_q", int'(io.ADC_Q), -316);
    check("hold_valid", int'(io.ADC_valid), 0);

    // Saturation at both rails, then a non-saturating sample
    cfg(0, 4, 0, 0, 0, 0, 1'b0);
    send(2047, -2048, 2047, -2048);
    send(100, -100, 400, -400);
    idle(6);
    check("sat_cnt_one", int'(sat_cnt), 1);

    // Delay of 5 samples (this load also clears SAT_CNT)
    cfg(0, 1, 0, 0, 0, 5, 1'b0);
    o0 = out_cnt;
    for (int k = 0; k < 20; k++) send(3 * k + 1, -(3 * k + 1), 3 * k + 1, -(3 * k + 1));
    idle(6);
    check("delay_count", out_cnt - o0, 15);

    // Reload mid-stream; the sample offered in the load cycle is dropped
    for (int k = 0; k < 10; k++) send(500 + k, -500 - k, 500 + k, -500 - k);
    cfg(0, 1, 0, 0, 0, 5, 1'b1);
    o0 = out_cnt;
    for (int k = 0; k < 8; k++) send(600 + k, 7 * k, 600 + k, 7 * k);
    idle(6);
    check("reload_count", out_cnt - o0, 3);

    // Asynchronous reset in the middle of a burst under a non-identity config
    cfg(2, 2, 0, 0, 0, 0, 1'b0);
    send(100, 50, -200, -100);
    send(300, -7, -600, 14);
    send(5, 6, -10, -12);
    send(-1, 1, 2, -2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    io.DAC_valid = 1'b0;
    model_reset();
    #1;
    check("midrst_adc_i", int'(io.ADC_I), 0);
    check("midrst_adc_q", int'(io.ADC_Q), 0);
    check("midrst_valid", int'(io.ADC_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(123, -45, 123, -45);
    idle(6);

    // Noise, 5 bits, continuing the LFSR sequence from the seed
    cfg(0, 1, 0, 5, 0, 0, 1'b0);
    noise_phase = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ei = int'(lfsr_i_m[4:0]) - 16;
      eq = int'(lfsr_q_m[4:0]) - 16;
      send(0, 0, ei, eq);
    end
    idle(6);
    noise_phase = 1'b0;
    check("noise_range", range_bad, 0);
    // Mean of [-16,15] is centred on -0.5; allow about one unit around that
    check("noise_mean_i", int'(sum_i_obs >= -2000 && sum_i_obs <= 1000), 1);
    check("noise_mean_q", int'(sum_q_obs >= -2000 && sum_q_obs <= 1000), 1);

    // Noise width above the maximum clamps to 6 bits
    cfg(0, 1, 0, 7, 0, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      ei = int'(lfsr_i_m[5:0]) - 32;
      eq = int'(lfsr_q_m[5:0]) - 32;
      send(0, 0, ei, eq);
    end
    idle(6);

    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
